// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, control-bundle types and helpers for the pipeline control tracker
package pipe_pkg;

    localparam logic [4:0] LINK_RN = 5'd31;

    typedef enum logic [3:0] {
        ALUC_ADD = 4'b0000,
        ALUC_AND = 4'b0001,
        ALUC_XOR = 4'b0010,
        ALUC_SLL = 4'b0011,
        ALUC_SUB = 4'b0100,
        ALUC_OR  = 4'b0101,
        ALUC_LUI = 4'b0110,
        ALUC_SRL = 4'b0111,
        ALUC_SRA = 4'b1111
    } aluc_e;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       aluimm;
        logic       shift;
        logic       jal;
        aluc_e      aluc;
        logic [4:0] rn;
    } ctrl_e_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [4:0] rn;
    } ctrl_m_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rn;
    } ctrl_w_t;

    // I-type instructions write rt, R-type write rd; jal is resolved later in E.
    function automatic logic [4:0] dest_rn(input logic regrt, input logic [4:0] rt, input logic [4:0] rd);
        return regrt ? rt : rd;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// rtl/pipe_ctrl_stage.sv - pipeline control register with async clear and synchronous bubble
module pipe_ctrl_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // A bubble loads all-zero controls so nothing downstream writes or stores.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            data_q <= '0;
        end else if (bubble_i) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl_track.sv
// rtl/pipe_ctrl_track.sv - ID/EXE, EXE/MEM, MEM/WB control tracker; PIPE_CTRL_PERF_EN adds stall/retire counters
module pipe_ctrl_track #(
    parameter logic [4:0] LINK_RN = pipe_pkg::LINK_RN
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             dvalid,
    input  logic             nostall,
    input  logic             wreg,
    input  logic             m2reg,
    input  logic             wmem,
    input  logic             aluimm,
    input  logic             shift,
    input  logic             jal,
    input  logic             regrt,
    input  logic [3:0]       aluc,
    input  logic [4:0]       rd,
    input  logic [4:0]       rt,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic             ealuimm,
    output logic             eshift,
    output logic             ejal,
    output logic [3:0]       ealuc,
    output logic [4:0]       ern,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [4:0]       mrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [4:0]       wrn
`ifdef PIPE_CTRL_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] retire_cnt
`endif
);

    import pipe_pkg::*;

    localparam int E_W = $bits(ctrl_e_t);
    localparam int M_W = $bits(ctrl_m_t);
    localparam int W_W = $bits(ctrl_w_t);

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;

    // Pack the ID control bundle with its resolved (pre-jal) destination.
    always_comb begin
        e_d        = '0;
        e_d.wreg   = wreg;
        e_d.m2reg  = m2reg;
        e_d.wmem   = wmem;
        e_d.aluimm = aluimm;
        e_d.shift  = shift;
        e_d.jal    = jal;
        e_d.aluc   = aluc_e'(aluc);
        e_d.rn     = dest_rn(regrt, rt, rd);
    end

    // jal link override lives in E so ern depends only on E-stage state.
    assign ern = e_q.jal ? LINK_RN : e_q.rn;

    // M and W simply forward the subsets they need from the previous stage.
    always_comb begin
        m_d       = '0;
        m_d.wreg  = e_q.wreg;
        m_d.m2reg = e_q.m2reg;
        m_d.wmem  = e_q.wmem;
        m_d.rn    = ern;
        w_d       = '0;
        w_d.wreg  = m_q.wreg;
        w_d.m2reg = m_q.m2reg;
        w_d.rn    = m_q.rn;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic             evalid, mvalid, wvalid;
    logic [CNT_W-1:0] stall_cnt_q, retire_cnt_q;

    pipe_ctrl_stage #(.W(E_W + 1)) u_stage_e (
        .clk(clk), .clrn(clrn), .bubble_i(~nostall),
        .d_i({e_d, dvalid}), .q_o({e_q, evalid})
    );
    pipe_ctrl_stage #(.W(M_W + 1)) u_stage_m (
        .clk(clk), .clrn(clrn), .bubble_i(1'b0),
        .d_i({m_d, evalid}), .q_o({m_q, mvalid})
    );
    pipe_ctrl_stage #(.W(W_W + 1)) u_stage_w (
        .clk(clk), .clrn(clrn), .bubble_i(1'b0),
        .d_i({w_d, mvalid}), .q_o({w_q, wvalid})
    );

    // Stalled real instructions and WB retirements, both wrapping freely.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (dvalid && !nostall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (wvalid) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    logic unused_dvalid;

    pipe_ctrl_stage #(.W(E_W)) u_stage_e (
        .clk(clk), .clrn(clrn), .bubble_i(~nostall), .d_i(e_d), .q_o(e_q)
    );
    pipe_ctrl_stage #(.W(M_W)) u_stage_m (
        .clk(clk), .clrn(clrn), .bubble_i(1'b0), .d_i(m_d), .q_o(m_q)
    );
    pipe_ctrl_stage #(.W(W_W)) u_stage_w (
        .clk(clk), .clrn(clrn), .bubble_i(1'b0), .d_i(w_d), .q_o(w_q)
    );

    assign unused_dvalid = dvalid;
`endif

    assign ewreg   = e_q.wreg;
    assign em2reg  = e_q.m2reg;
    assign ewmem   = e_q.wmem;
    assign ealuimm = e_q.aluimm;
    assign eshift  = e_q.shift;
    assign ejal    = e_q.jal;
    assign ealuc   = e_q.aluc;
    assign mwreg   = m_q.wreg;
    assign mm2reg  = m_q.m2reg;
    assign mwmem   = m_q.wmem;
    assign mrn     = m_q.rn;
    assign wwreg   = w_q.wreg;
    assign wm2reg  = w_q.m2reg;
    assign wrn     = w_q.rn;

endmodule
